// File: rtl/mux4_rr_sel.sv
// mux4_rr_sel: round-robin 4:1 mux select generator with dwell-limited grants
module mux4_rr_sel #(
  parameter int DWELL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  input  logic       ack,
  output logic       S1,
  output logic       S0,
  output logic [3:0] grant,
  output logic       valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] sel, sel_n, last, last_n, base, pick;
  logic [3:0] grant_n;
  logic [7:0] cnt, cnt_n;
  logic valid_n, timeout_n, rdy, lim, done;
  assign S1 = sel[1];
  assign S0 = sel[0];
  assign base = (state == GRANT) ? sel : last;
  assign lim = cnt == 8'(DWELL - 1);
  assign done = (state == GRANT) && (ack || lim);
  // first requester after base, wrapping; base itself wins only when sole requester
  always_comb begin
    pick = base;
    for (int i = 3; i >= 1; i--) if (req[base + 2'(i)]) pick = base + 2'(i);
  end
  // next-state and registered-output values
  always_comb begin
    state_n = state;
    sel_n = sel;
    grant_n = grant;
    valid_n = valid;
    timeout_n = 1'b0;
    cnt_n = cnt;
    last_n = last;
    if (state == IDLE) begin
      if (rdy && en && |req) begin
        state_n = GRANT;
        sel_n = pick;
        grant_n = 4'b1 << pick;
        valid_n = 1'b1;
        cnt_n = '0;
      end else begin
        valid_n = 1'b0;
        grant_n = '0;
      end
    end else if (done) begin
      last_n = sel;
      timeout_n = !ack;
      cnt_n = '0;
      if (en && |req) begin
        sel_n = pick;
        grant_n = 4'b1 << pick;
      end else begin
        state_n = IDLE;
        valid_n = 1'b0;
        grant_n = '0;
      end
    end else begin
      cnt_n = cnt + 8'd1;
    end
  end
  // state registers; rdy delays the first grant to the second edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      grant <= '0;
      valid <= 1'b0;
      timeout <= 1'b0;
      cnt <= '0;
      last <= 2'd3;
      rdy <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      grant <= grant_n;
      valid <= valid_n;
      timeout <= timeout_n;
      cnt <= cnt_n;
      last <= last_n;
      rdy <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux4_rr_sel.sv
// tb_mux4_rr_sel: table-driven and directed checks of mux4_rr_sel with DWELL=8
module tb_mux4_rr_sel;
  logic clk, rst_n, en, ack, S1, S0, valid, timeout;
  logic [3:0] req, grant;
  int checks = 0, failures = 0;
  typedef struct {
    logic en;
    logic [3:0] req;
    logic ack;
    logic [1:0] sel;
    logic [3:0] g;
    logic v;
    logic t;
  } vec_t;
  vec_t tv[19];
  mux4_rr_sel #(.DWELL(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ack(ack),
    .S1(S1), .S0(S0), .grant(grant), .valid(valid), .timeout(timeout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [1:0] s, input logic [3:0] g, input logic v, input logic t);
    logic [7:0] got, exp;
    got = {S1, S0, grant, valid, timeout};
    exp = {s, g, v, t};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got sel=%b grant=%b valid=%b timeout=%b, expected sel=%b grant=%b valid=%b timeout=%b",
               nm, got[7:6], got[5:2], got[1], got[0], s, g, v, t);
    end
  endtask
  task automatic step(input string nm, input logic e, input logic [3:0] r, input logic a,
                      input logic [1:0] s, input logic [3:0] g, input logic v, input logic t);
    en = e;
    req = r;
    ack = a;
    @(posedge clk);
    #1;
    chk(nm, s, g, v, t);
  endtask
  initial begin
    tv[0]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 4'b0000, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b0};
    tv[10] = '{1'b1, 4'b0000, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0};
    tv[11] = '{1'b1, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0};
    tv[12] = '{1'b0, 4'b1111, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0};
    tv[13] = '{1'b1, 4'b1000, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
    tv[14] = '{1'b0, 4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0};
    tv[15] = '{1'b0, 4'b1111, 1'b1, 2'd3, 4'b0000, 1'b0, 1'b0};
    tv[16] = '{1'b0, 4'b1111, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0};
    tv[17] = '{1'b1, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0};
    tv[18] = '{1'b1, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
    rst_n = 1'b0;
    en = 1'b0;
    req = 4'b0000;
    ack = 1'b0;
    #2;
    chk("reset_state", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 19; i++)
      step($sformatf("vec%0d", i), tv[i].en, tv[i].req, tv[i].ack, tv[i].sel, tv[i].g, tv[i].v, tv[i].t);
    for (int i = 0; i < 8; i++) step($sformatf("dwell_hold%0d", i), 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
    step("timeout_pulse", 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b1);
    step("timeout_single", 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
    step("timeout_end", 1'b1, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0);
    step("lim_ack_entry", 1'b1, 4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step($sformatf("lim_ack_hold%0d", i), 1'b1, 4'b1111, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0);
    step("lim_ack_prec", 1'b1, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0);
    step("lim_ack_end", 1'b1, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0);
    step("rst_mid_grant", 1'b1, 4'b0100, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0);
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_rst_wait", 1'b1, 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0);
    step("post_rst_ch0", 1'b1, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0);
    step("post_rst_ch1", 1'b1, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
